stepper_strobe_ctrl: RTL and testbench
======================================

Name: stepper_strobe_ctrl

Overview:
Parametrised stepper-motor move controller. It counts synchronised rising edges on a strobe input. After STB_COUNT edges it runs one move of STEPS phase advances on a 4-wire bipolar stepper, with each phase held STEP_DIV clocks. The block replaces the fixed strobe/fixed-duration motor enable. It adds direction, half/full-step mode, abort, hold-torque option and busy/done status, and it drives the coil pins directly.

Parameters:
STB_COUNT, 6, strobe edges needed to start a move (>=1)
STEPS, 100, phase advances per move (>=1)
STEP_DIV, 50000, clocks per phase dwell (>=2)
HOLD, 0, 1 = keep the last phase energised when idle; 0 = all coils off when idle

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
STB  in  1  asynchronous strobe, counted on rising edge
DIR  in  1  1 = forward (phase index +1), 0 = reverse (-1); latched at move start
HALF  in  1  1 = half-step, 0 = full-step; latched at move start
ABORT  in  1  synchronous, level; terminates a move
INA  out  1  coil A+
INB  out  1  coil B+
INA2  out  1  coil A-
INB2  out  1  coil B-
BUSY  out  1  high while a move runs
DONE  out  1  one-cycle pulse when a move completes normally
STB_CNT  out  $clog2(STB_COUNT+1)  strobe edges counted so far

Behaviour:
- Clock and reset: single clock CLK. RST_N is asynchronous and active-low.
- Reset state: {INA,INB,INA2,INB2}=0000, BUSY=0, DONE=0, STB_CNT=0, phase index=1, FSM=IDLE, dividers cleared.
- STB synchronisation: STB passes through a 2-flop synchroniser, then an edge register. An edge is detected exactly once per low-to-high transition. A held-high STB counts once.
- Phase table, 3-bit index, coil order {INA,INB,INA2,INB2}:
  - 0:1000, 1:1100, 2:0100, 3:0110, 4:0010, 5:0011, 6:0001, 7:1001
- Stepping: half-step moves the index by ±1 mod 8. Full-step moves it by ±2 mod 8 and uses odd indices only.
- IDLE state:
  - Each detected edge increments STB_CNT.
  - On the edge that makes the count equal STB_COUNT: STB_CNT clears, DIR and HALF are latched, and the FSM enters RUN on the next clock.
  - In full-step mode, entry forces index = index|1. This snap is not counted as a step.
- RUN state:
  - BUSY=1. Coils show the current phase.
  - The dwell counter counts 0..STEP_DIV-1. At each wrap the index advances one step and the advance counter increments.
  - The initial phase is held STEP_DIV clocks. Each of the STEPS advanced phases is also held STEP_DIV clocks.
  - When the final dwell ends, the FSM returns to IDLE. BUSY is high for exactly (STEPS+1)*STEP_DIV clocks. DONE pulses for 1 clock on the first IDLE cycle.
- Strobes during RUN are ignored. They are not counted or queued, and STB_CNT stays 0.
- ABORT in RUN: the FSM goes to IDLE on the next clock. DONE is not asserted. The phase index keeps its current value, and the divider and advance counters clear.
- ABORT in IDLE: STB_CNT clears to 0 and edges that cycle are ignored.
- Idle coils:
  - HOLD=1: coils show the phase at the current index. After reset this is 0000 until the first move.
  - HOLD=0: coils are 0000.
- Persistence: the phase index persists across moves, so consecutive moves continue the electrical sequence.
- Registered outputs: all outputs are registered, and coils never show an unlisted pattern. Only one phase changes per advance.
- Reset mid-move: all state returns to reset values immediately, without waiting for a clock.

Test Plan:
(Benches use STB_COUNT=3, STEPS=4, STEP_DIV=5 unless stated.)
1. Reset: assert RST_N=0 with no clock running -> coils 0000, BUSY=0, DONE=0, STB_CNT=0. Release, then 2 STB pulses -> STB_CNT=2, BUSY=0.
2. 3 STB pulses, DIR=1, HALF=0, HOLD=0 -> coils 1100,0110,0011,1001,1100, 5 clocks each. BUSY high 25 clocks, one DONE pulse, then coils 0000.
3. Following move with DIR=0, HALF=1 (index starts at 1) -> 1100,1000,1001,0001,0011. Final index 5.
4. During RUN: 4 STB pulses plus STB held high 40 clocks -> no extra move, STB_CNT=0 throughout. After BUSY falls, the held level alone starts nothing; 3 new pulses start the next move.
5. ABORT raised 12 clocks into a move -> BUSY low on the next clock, no DONE pulse. With HOLD=1 the coils keep the aborted phase. The next move resumes from that index.
6. RST_N pulsed low mid-RUN, between clock edges -> outputs 0000 and BUSY=0 immediately. After release, 3 strobes are needed again, starting from phase 1100.

Source files
------------

// File: rtl/stepper_strobe_ctrl_if.sv
// Strobe/command inputs and coil/status outputs of the stepper move controller.
// Asynchronous strobe in; fully registered outputs; no backpressure.
interface stepper_strobe_ctrl_if #(
  parameter int CNT_W = 3
);
  logic             STB;
  logic             DIR;
  logic             HALF;
  logic             ABORT;
  logic             INA;
  logic             INB;
  logic             INA2;
  logic             INB2;
  logic             BUSY;
  logic             DONE;
  logic [CNT_W-1:0] STB_CNT;

  modport master (
    output STB, DIR, HALF, ABORT,
    input  INA, INB, INA2, INB2, BUSY, DONE, STB_CNT
  );

  modport slave (
    input  STB, DIR, HALF, ABORT,
    output INA, INB, INA2, INB2, BUSY, DONE, STB_CNT
  );
endinterface

// File: rtl/stepper_strobe_ctrl.sv
// Counts synchronised STB edges, then steps a bipolar motor STEPS phases of STEP_DIV clocks each.
// Move starts 3 clocks after the final strobe rises; outputs registered; no backpressure (strobes during a move are dropped).
module stepper_strobe_ctrl #(
  parameter int STB_COUNT = 6,
  parameter int STEPS     = 100,
  parameter int STEP_DIV  = 50000,
  parameter bit HOLD      = 1'b0
) (
  input logic                  CLK,
  input logic                  RST_N,
  stepper_strobe_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(STB_COUNT + 1);
  localparam int DIV_W = $clog2(STEP_DIV);
  localparam int ADV_W = $clog2(STEPS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STB_COUNT - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [ADV_W-1:0] ADV_LAST = ADV_W'(STEPS);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic             stb_s1_q, stb_s1_d;
  logic             stb_s2_q, stb_s2_d;
  logic             stb_s3_q, stb_s3_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             dir_q, dir_d;
  logic             half_q, half_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [ADV_W-1:0] adv_q, adv_d;
  logic             moved_q, moved_d;
  logic [3:0]       coils_q, coils_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             stb_rise;
  logic [2:0]       step;

  assign stb_rise = stb_s2_q & ~stb_s3_q;
  assign step     = half_q ? 3'd1 : 3'd2;

  // Coil order {A+, B+, A-, B-}; adjacent entries differ in one coil.
  function automatic logic [3:0] phase_of(input logic [2:0] idx);
    case (idx)
      3'd0:    phase_of = 4'b1000;
      3'd1:    phase_of = 4'b1100;
      3'd2:    phase_of = 4'b0100;
      3'd3:    phase_of = 4'b0110;
      3'd4:    phase_of = 4'b0010;
      3'd5:    phase_of = 4'b0011;
      3'd6:    phase_of = 4'b0001;
      default: phase_of = 4'b1001;
    endcase
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      stb_s1_q <= 1'b0;
      stb_s2_q <= 1'b0;
      stb_s3_q <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= 3'd1;
      dir_q    <= 1'b0;
      half_q   <= 1'b0;
      div_q    <= '0;
      adv_q    <= '0;
      moved_q  <= 1'b0;
      coils_q  <= 4'b0000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      stb_s1_q <= stb_s1_d;
      stb_s2_q <= stb_s2_d;
      stb_s3_q <= stb_s3_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      dir_q    <= dir_d;
      half_q   <= half_d;
      div_q    <= div_d;
      adv_q    <= adv_d;
      moved_q  <= moved_d;
      coils_q  <= coils_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    stb_s1_d = bus.STB;
    stb_s2_d = stb_s1_q;
    stb_s3_d = stb_s2_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    dir_d    = dir_q;
    half_d   = half_q;
    div_d    = div_q;
    adv_d    = adv_q;
    moved_d  = moved_q;
    case (state_q)
      IDLE: begin
        if (bus.ABORT) begin
          cnt_d = '0;
        end else if (stb_rise) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            dir_d   = bus.DIR;
            half_d  = bus.HALF;
            moved_d = 1'b1;
            div_d   = '0;
            adv_d   = '0;
            state_d = RUN;
            // Full-step only uses the two-coil (odd) phases.
            if (!bus.HALF) idx_d = idx_q | 3'd1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.ABORT) begin
          state_d = IDLE;
          div_d   = '0;
          adv_d   = '0;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          if (adv_q == ADV_LAST) begin
            state_d = IDLE;
            adv_d   = '0;
          end else begin
            adv_d = adv_q + 1'b1;
            idx_d = dir_q ? idx_q + step : idx_q - step;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next-state so they register alongside the FSM.
  always_comb begin
    busy_d  = (state_d == RUN);
    done_d  = (state_q == RUN) && (state_d == IDLE) && !bus.ABORT;
    coils_d = 4'b0000;
    if ((state_d == RUN) || (HOLD && moved_d)) coils_d = phase_of(idx_d);
  end

  assign bus.INA     = coils_q[3];
  assign bus.INB     = coils_q[2];
  assign bus.INA2    = coils_q[1];
  assign bus.INB2    = coils_q[0];
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.STB_CNT = cnt_q;
endmodule

// File: tb/tb_stepper_strobe_ctrl.sv
// Directed bench for stepper_strobe_ctrl: STB_COUNT=3, STEPS=4, STEP_DIV=5.
// u_dut has HOLD=0, u_hold has HOLD=1; both see identical inputs.
module tb_stepper_strobe_ctrl;
  logic CLK    = 1'b0;
  logic RST_N  = 1'b1;
  logic clk_en = 1'b0;
  int   checks = 0;
  int   passed = 0;

  always #5 if (clk_en) CLK = ~CLK;

  stepper_strobe_ctrl_if #(.CNT_W(2)) if0 ();
  stepper_strobe_ctrl_if #(.CNT_W(2)) if1 ();

  assign if1.STB   = if0.STB;
  assign if1.DIR   = if0.DIR;
  assign if1.HALF  = if0.HALF;
  assign if1.ABORT = if0.ABORT;

  stepper_strobe_ctrl #(.STB_COUNT(3), .STEPS(4), .STEP_DIV(5), .HOLD(1'b0)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .bus(if0.slave)
  );
  stepper_strobe_ctrl #(.STB_COUNT(3), .STEPS(4), .STEP_DIV(5), .HOLD(1'b1)) u_hold (
    .CLK(CLK), .RST_N(RST_N), .bus(if1.slave)
  );

  logic [3:0] c0, c1;
  assign c0 = {if0.INA, if0.INB, if0.INA2, if0.INB2};
  assign c1 = {if1.INA, if1.INB, if1.INA2, if1.INB2};

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse();
    if0.STB = 1'b1;
    tick(); tick();
    if0.STB = 1'b0;
    tick(); tick(); tick();
  endtask

  // Raises the final strobe and returns clocks until BUSY is seen (bounded).
  task automatic start_move(output int lat);
    if0.STB = 1'b1;
    lat = 0;
    while (!if0.BUSY && lat < 10) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    #10;
    checks++; if ({c0, c1} !== 8'h00) $display("FAIL reset_coils got=%b/%b want=0000/0000", c0, c1); else passed++;
    checks++; if ({if0.BUSY, if0.DONE, if1.BUSY, if1.DONE} !== 4'b0000)
      $display("FAIL reset_status got=%b want=0000", {if0.BUSY, if0.DONE, if1.BUSY, if1.DONE}); else passed++;
    checks++; if (if0.STB_CNT !== 2'd0) $display("FAIL reset_stb_cnt got=%0d want=0", if0.STB_CNT); else passed++;
    RST_N = 1'b1;
    #5;
    clk_en = 1'b1;
    tick();
    pulse();
    checks++; if (if0.STB_CNT !== 2'd1) $display("FAIL cnt_after_1 got=%0d want=1", if0.STB_CNT); else passed++;
    pulse();
    checks++; if (if0.STB_CNT !== 2'd2) $display("FAIL cnt_after_2 got=%0d want=2", if0.STB_CNT); else passed++;
    checks++; if (if0.BUSY !== 1'b0) $display("FAIL busy_after_2 got=%b want=0", if0.BUSY); else passed++;
    checks++; if (c1 !== 4'b0000) $display("FAIL hold_before_move got=%b want=0000", c1); else passed++;
  endtask

  task automatic test_full_forward();
    int lat;
    logic [19:0] seq;
    seq = {4'b1100, 4'b0110, 4'b0011, 4'b1001, 4'b1100};
    if0.ABORT = 1'b1;
    pulse();
    if0.ABORT = 1'b0;
    checks++; if (if0.STB_CNT !== 2'd0) $display("FAIL abort_idle_cnt got=%0d want=0", if0.STB_CNT); else passed++;
    if0.DIR = 1'b1; if0.HALF = 1'b0;
    pulse(); pulse();
    start_move(lat);
    if0.STB = 1'b0;
    checks++; if (lat !== 3) $display("FAIL fwd_start_latency got=%0d want=3", lat); else passed++;
    for (int i = 0; i < 25; i++) begin
      if (i == 7) begin if0.DIR = 1'b0; if0.HALF = 1'b1; end
      checks++;
      if (c0 !== seq[19 - 4 * (i / 5) -: 4] || if0.BUSY !== 1'b1)
        $display("FAIL fwd_phase cyc=%0d got=%b busy=%b want=%b busy=1", i, c0, if0.BUSY, seq[19 - 4 * (i / 5) -: 4]);
      else passed++;
      tick();
    end
    checks++; if ({if0.BUSY, if0.DONE, c0} !== 6'b010000)
      $display("FAIL fwd_end got busy=%b done=%b coils=%b want 0,1,0000", if0.BUSY, if0.DONE, c0); else passed++;
    tick();
    checks++; if (if0.DONE !== 1'b0) $display("FAIL fwd_done_width got=%b want=0", if0.DONE); else passed++;
  endtask

  task automatic test_half_reverse();
    int lat;
    logic [19:0] seq;
    seq = {4'b1100, 4'b1000, 4'b1001, 4'b0001, 4'b0011};
    if0.DIR = 1'b0; if0.HALF = 1'b1;
    pulse(); pulse();
    start_move(lat);
    if0.STB = 1'b0;
    checks++; if (lat !== 3) $display("FAIL rev_start_latency got=%0d want=3", lat); else passed++;
    for (int i = 0; i < 25; i++) begin
      checks++;
      if (c0 !== seq[19 - 4 * (i / 5) -: 4] || if0.BUSY !== 1'b1)
        $display("FAIL rev_phase cyc=%0d got=%b busy=%b want=%b busy=1", i, c0, if0.BUSY, seq[19 - 4 * (i / 5) -: 4]);
      else passed++;
      tick();
    end
    checks++; if ({if0.BUSY, if0.DONE, c0, c1} !== 10'b01_0000_0011)
      $display("FAIL rev_end got busy=%b done=%b coils=%b hold=%b want 0,1,0000,0011", if0.BUSY, if0.DONE, c0, c1); else passed++;
    tick();
  endtask

  task automatic test_strobes_during_run();
    int lat;
    int busy_n;
    int done_n;
    int n;
    if0.DIR = 1'b1; if0.HALF = 1'b1;
    pulse(); pulse();
    start_move(lat);
    checks++; if (lat !== 3) $display("FAIL run_start_latency got=%0d want=3", lat); else passed++;
    checks++; if (c0 !== 4'b0011) $display("FAIL run_first_phase got=%b want=0011", c0); else passed++;
    busy_n = 0;
    done_n = 0;
    for (int i = 0; i < 60; i++) begin
      if0.STB = (i < 20) ? ((i % 5 == 2) || (i % 5 == 3)) : 1'b1;
      busy_n += int'(if0.BUSY);
      done_n += int'(if0.DONE);
      checks++; if (if0.STB_CNT !== 2'd0) $display("FAIL run_stb_cnt cyc=%0d got=%0d want=0", i, if0.STB_CNT); else passed++;
      tick();
    end
    checks++; if (busy_n !== 25) $display("FAIL run_busy_len got=%0d want=25", busy_n); else passed++;
    checks++; if (done_n !== 1) $display("FAIL run_done_count got=%0d want=1", done_n); else passed++;
    if0.STB = 1'b0;
    tick(); tick(); tick();
    checks++; if ({if0.BUSY, if0.STB_CNT} !== 3'b000)
      $display("FAIL held_level_start busy=%b cnt=%0d want 0,0", if0.BUSY, if0.STB_CNT); else passed++;
    pulse(); pulse(); pulse();
    checks++; if ({if0.BUSY, c0} !== 5'b1_1100) $display("FAIL next_move busy=%b coils=%b want 1,1100", if0.BUSY, c0); else passed++;
    n = 0;
    while (!if0.DONE && n < 40) begin
      tick();
      n++;
    end
    checks++; if (if0.DONE !== 1'b1) $display("FAIL next_move_done got=%b want=1 after %0d clocks", if0.DONE, n); else passed++;
    tick();
  endtask

  task automatic test_abort();
    int lat;
    int done_n;
    logic [19:0] seq;
    seq = {4'b1100, 4'b1000, 4'b1001, 4'b0001, 4'b0011};
    if0.DIR = 1'b1; if0.HALF = 1'b0;
    pulse(); pulse();
    start_move(lat);
    if0.STB = 1'b0;
    checks++; if (lat !== 3) $display("FAIL abort_start_latency got=%0d want=3", lat); else passed++;
    checks++; if (c1 !== 4'b0011) $display("FAIL abort_first_phase got=%b want=0011", c1); else passed++;
    for (int i = 0; i < 12; i++) tick();
    checks++; if (c1 !== 4'b1100) $display("FAIL abort_pre_phase got=%b want=1100", c1); else passed++;
    if0.ABORT = 1'b1;
    tick();
    if0.ABORT = 1'b0;
    checks++; if ({if0.BUSY, if1.BUSY, if0.DONE, if1.DONE} !== 4'b0000)
      $display("FAIL abort_status got=%b want=0000", {if0.BUSY, if1.BUSY, if0.DONE, if1.DONE}); else passed++;
    checks++; if ({c0, c1} !== 8'b0000_1100) $display("FAIL abort_coils got=%b/%b want=0000/1100", c0, c1); else passed++;
    done_n = 0;
    for (int i = 0; i < 30; i++) begin
      done_n += int'(if0.DONE) + int'(if1.DONE);
      tick();
    end
    checks++; if (done_n !== 0) $display("FAIL abort_no_done got=%0d want=0", done_n); else passed++;
    if0.DIR = 1'b0; if0.HALF = 1'b1;
    pulse(); pulse();
    start_move(lat);
    if0.STB = 1'b0;
    for (int i = 0; i < 25; i++) begin
      checks++;
      if (c1 !== seq[19 - 4 * (i / 5) -: 4])
        $display("FAIL resume_phase cyc=%0d got=%b want=%b", i, c1, seq[19 - 4 * (i / 5) -: 4]);
      else passed++;
      tick();
    end
    checks++; if ({if1.BUSY, if1.DONE, c1, c0} !== 10'b01_0011_0000)
      $display("FAIL resume_end got busy=%b done=%b hold=%b coils=%b want 0,1,0011,0000", if1.BUSY, if1.DONE, c1, c0); else passed++;
    tick();
  endtask

  task automatic test_reset_mid_move();
    int lat;
    int n;
    if0.DIR = 1'b1; if0.HALF = 1'b1;
    pulse(); pulse();
    start_move(lat);
    if0.STB = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    #2;
    RST_N = 1'b0;
    #1;
    checks++; if ({c0, c1} !== 8'h00) $display("FAIL midrst_coils got=%b/%b want=0000/0000", c0, c1); else passed++;
    checks++; if ({if0.BUSY, if1.BUSY, if0.STB_CNT} !== 4'b0000)
      $display("FAIL midrst_status busy=%b/%b cnt=%0d want 0/0,0", if0.BUSY, if1.BUSY, if0.STB_CNT); else passed++;
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    pulse(); pulse();
    checks++; if ({if0.STB_CNT, if0.BUSY, c1} !== 7'b10_0_0000)
      $display("FAIL midrst_rearm cnt=%0d busy=%b hold=%b want 2,0,0000", if0.STB_CNT, if0.BUSY, c1); else passed++;
    start_move(lat);
    if0.STB = 1'b0;
    checks++; if (lat !== 3) $display("FAIL midrst_start_latency got=%0d want=3", lat); else passed++;
    checks++; if ({c0, c1} !== 8'b1100_1100) $display("FAIL midrst_first_phase got=%b/%b want=1100/1100", c0, c1); else passed++;
    n = 0;
    while (!if0.DONE && n < 40) begin
      tick();
      n++;
    end
    checks++; if (if0.DONE !== 1'b1) $display("FAIL midrst_done got=%b want=1 after %0d clocks", if0.DONE, n); else passed++;
  endtask

  initial begin
    if0.STB   = 1'b0;
    if0.DIR   = 1'b0;
    if0.HALF  = 1'b0;
    if0.ABORT = 1'b0;
    #1;
    test_reset();
    test_full_forward();
    test_half_reverse();
    test_strobes_during_run();
    test_abort();
    test_reset_mid_move();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
